// File: rtl/boss_projectile_engine_pkg.sv
// ---------------------------------------------------------------------------
// boss_projectile_engine_pkg
// Shared definitions for the boss projectile engine: attack-type codes,
// playfield bounds, volley geometry, load-FSM states and the box-overlap
// helper used by every projectile slot.
// ---------------------------------------------------------------------------
package boss_projectile_engine_pkg;

    // Attack-type codes as delivered by the boss controller.
    typedef enum logic [1:0] {
        ATK_PROJ = 2'b00,   // straight down
        ATK_BEAM = 2'b01,   // stationary, time-limited
        ATK_DIAG = 2'b10,   // diagonal down-left / down-right
        ATK_NONE = 2'b11    // volley ignored
    } attack_t;

    typedef enum logic {
        ST_IDLE,
        ST_LOAD
    } load_state_t;

    // One spawn position within a volley.
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } coord_t;

    localparam int VOLLEY_SIZE = 5;

    // Playfield bounds in 11-bit form so motion arithmetic never wraps.
    localparam logic [10:0] X_MIN = 11'd144;   // inclusive
    localparam logic [10:0] X_MAX = 11'd784;   // exclusive
    localparam logic [10:0] Y_MAX = 11'd511;   // exclusive

    // Axis-aligned box overlap; sums are widened by one bit to avoid wrap.
    function automatic logic box_overlap(
        input logic [9:0] ax, input logic [8:0] ay,
        input logic [9:0] aw, input logic [8:0] ah,
        input logic [9:0] bx, input logic [8:0] by,
        input logic [9:0] bw, input logic [8:0] bh
    );
        return ({1'b0, ax} < ({1'b0, bx} + {1'b0, bw})) &&
               ({1'b0, bx} < ({1'b0, ax} + {1'b0, aw})) &&
               ({1'b0, ay} < ({1'b0, by} + {1'b0, bh})) &&
               ({1'b0, by} < ({1'b0, ay} + {1'b0, ah}));
    endfunction

endpackage

// File: rtl/boss_projectile_engine_proj_slot.sv
// ---------------------------------------------------------------------------
// proj_slot
// One projectile slot: holds position/size/type, advances once per frame,
// retires itself when it leaves the playfield, hits a player (proj/diag)
// or a beam's lifetime expires, and reports a player overlap on the frame.
//
// Ports
//   clk_master, rst        clock, synchronous active-high reset
//   pulse_frame            one-cycle frame tick
//   wr_en                  load spawn values into this slot (wins over motion)
//   wr_type, wr_dir_left   attack type and diagonal direction of the spawn
//   wr_x/wr_y/wr_w/wr_h    spawn box
//   player_x/y/w/h         player box for the overlap test
//   valid, x, y, w, h      current slot state for the renderer
//   hit                    combinational: this slot overlaps the player on
//                          the current frame tick (pre-update position)
// ---------------------------------------------------------------------------
module proj_slot
    import boss_projectile_engine_pkg::*;
#(
    parameter int PROJ_SPEED = 4,
    parameter int DIAG_SPEED = 3,
    parameter int BEAM_LIFE  = 60
) (
    input  logic        clk_master,
    input  logic        rst,
    input  logic        pulse_frame,
    input  logic        wr_en,
    input  attack_t     wr_type,
    input  logic        wr_dir_left,
    input  logic [9:0]  wr_x,
    input  logic [8:0]  wr_y,
    input  logic [9:0]  wr_w,
    input  logic [8:0]  wr_h,
    input  logic [9:0]  player_x,
    input  logic [8:0]  player_y,
    input  logic [9:0]  player_w,
    input  logic [8:0]  player_h,
    output logic        valid,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [9:0]  w,
    output logic [8:0]  h,
    output logic        hit
);

    attack_t    type_q;
    logic       dir_left_q;
    logic [7:0] life_q;
    logic       spent_q;

    logic [10:0] next_x;
    logic [10:0] next_y;
    logic [11:0] next_right;
    logic        x_under;
    logic        out_of_bounds;
    logic        beam_expire;
    logic        retire;

    // NOTE: every signal assigned in always_comb gets a default at the top so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_x  = {1'b0, x};
        next_y  = {2'b0, y};
        x_under = 1'b0;
        case (type_q)
            ATK_PROJ: next_y = {2'b0, y} + 11'(PROJ_SPEED);
            ATK_DIAG: begin
                next_y = {2'b0, y} + 11'(DIAG_SPEED);
                if (dir_left_q) begin
                    // Moving left past zero counts as leaving the playfield.
                    x_under = ({1'b0, x} < 11'(DIAG_SPEED));
                    next_x  = {1'b0, x} - 11'(DIAG_SPEED);
                end else begin
                    next_x  = {1'b0, x} + 11'(DIAG_SPEED);
                end
            end
            default: ;
        endcase

        next_right    = {1'b0, next_x} + {2'b0, w};
        out_of_bounds = (next_y >= Y_MAX) || x_under || (next_x < X_MIN) ||
                        (next_right > {1'b0, X_MAX});
        beam_expire   = (type_q == ATK_BEAM) && (life_q == 8'd1);

        // A spent beam stays visible but can never hit again.
        hit    = pulse_frame && valid && !spent_q &&
                 box_overlap(x, y, w, h, player_x, player_y, player_w, player_h);
        retire = out_of_bounds || beam_expire || (hit && (type_q != ATK_BEAM));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // slot samples the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_master) begin
        if (rst) begin
            valid      <= 1'b0;
            type_q     <= ATK_PROJ;
            dir_left_q <= 1'b0;
            life_q     <= '0;
            spent_q    <= 1'b0;
            x          <= '0;
            y          <= '0;
            w          <= '0;
            h          <= '0;
        end else if (wr_en) begin
            // A fresh spawn skips motion on a coincident frame tick.
            valid      <= 1'b1;
            type_q     <= wr_type;
            dir_left_q <= wr_dir_left;
            life_q     <= 8'(BEAM_LIFE);
            spent_q    <= 1'b0;
            x          <= wr_x;
            y          <= wr_y;
            w          <= wr_w;
            h          <= wr_h;
        end else if (pulse_frame && valid) begin
            if (retire) begin
                valid <= 1'b0;
            end else begin
                x <= next_x[9:0];
                y <= next_y[8:0];
                if (type_q == ATK_BEAM) begin
                    life_q <= life_q - 8'd1;
                end
                if (hit) begin
                    spent_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/boss_projectile_engine.sv
// ---------------------------------------------------------------------------
// boss_projectile_engine
// Captures boss volley descriptors, loads up to five projectiles into a pool
// of SLOTS slots (one entry per cycle), advances them every frame, and
// reports player hits and projectiles dropped because the pool was full.
//
// Ports
//   clk_master, rst             clock, synchronous active-high reset
//   pulse_frame                 one-cycle frame tick
//   bossShoot, attackType       volley strobe and type (11 = ignored)
//   proj1X..proj5X, proj1Y..    spawn coordinates; (0,0) marks an empty entry
//   projW, projH                size shared by the whole volley
//   playerX/Y/W/H               player box
//   slotValid                   per-slot valid
//   slotX/slotY/slotW/slotH     flattened slot buses, slot i at [N*i +: N]
//   playerHit                   one-cycle pulse after a frame with any hit
//   dropCount                   saturating count of projectiles lost
// ---------------------------------------------------------------------------
module boss_projectile_engine
    import boss_projectile_engine_pkg::*;
#(
    parameter int SLOTS      = 10,
    parameter int PROJ_SPEED = 4,
    parameter int DIAG_SPEED = 3,
    parameter int BEAM_LIFE  = 60
) (
    input  logic              clk_master,
    input  logic              rst,
    input  logic              pulse_frame,
    input  logic              bossShoot,
    input  logic [1:0]        attackType,
    input  logic [9:0]        proj1X,
    input  logic [9:0]        proj2X,
    input  logic [9:0]        proj3X,
    input  logic [9:0]        proj4X,
    input  logic [9:0]        proj5X,
    input  logic [8:0]        proj1Y,
    input  logic [8:0]        proj2Y,
    input  logic [8:0]        proj3Y,
    input  logic [8:0]        proj4Y,
    input  logic [8:0]        proj5Y,
    input  logic [9:0]        projW,
    input  logic [8:0]        projH,
    input  logic [9:0]        playerX,
    input  logic [8:0]        playerY,
    input  logic [9:0]        playerW,
    input  logic [8:0]        playerH,
    output logic [SLOTS-1:0]  slotValid,
    output logic [10*SLOTS-1:0] slotX,
    output logic [9*SLOTS-1:0]  slotY,
    output logic [10*SLOTS-1:0] slotW,
    output logic [9*SLOTS-1:0]  slotH,
    output logic              playerHit,
    output logic [7:0]        dropCount
);

    localparam int IDX_W = $clog2(SLOTS);

    load_state_t state_q;
    logic [2:0]  idx_q;

    coord_t      cap_entry [VOLLEY_SIZE];
    logic [9:0]  cap_w;
    logic [8:0]  cap_h;
    attack_t     cap_type;

    coord_t           cur_entry;
    logic             entry_live;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [SLOTS-1:0] wr_vec;
    logic [SLOTS-1:0] slot_hit;
    logic             capture;

    assign capture = (state_q == ST_IDLE) && bossShoot && (attack_t'(attackType) != ATK_NONE);

    // NOTE: capture registers carry no reset; they are only read during LOAD,
    // which is always preceded by a capture, so their reset value never matters.
    always_ff @(posedge clk_master) begin
        if (capture) begin
            cap_entry[0] <= '{x: proj1X, y: proj1Y};
            cap_entry[1] <= '{x: proj2X, y: proj2Y};
            cap_entry[2] <= '{x: proj3X, y: proj3Y};
            cap_entry[3] <= '{x: proj4X, y: proj4Y};
            cap_entry[4] <= '{x: proj5X, y: proj5Y};
            cap_w        <= projW;
            cap_h        <= projH;
            cap_type     <= attack_t'(attackType);
        end
    end

    // Current entry, lowest-index free slot, and the one-hot slot write.
    always_comb begin
        cur_entry  = cap_entry[idx_q];
        entry_live = (state_q == ST_LOAD) && !((cur_entry.x == '0) && (cur_entry.y == '0));

        free_found = 1'b0;
        free_idx   = '0;
        // Scan downward so the lowest free index is the last one assigned.
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!slotValid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        wr_vec = '0;
        if (entry_live && free_found) begin
            wr_vec[free_idx] = 1'b1;
        end
    end

    // Load FSM, hit pulse and drop counter.
    always_ff @(posedge clk_master) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            playerHit <= 1'b0;
            dropCount <= '0;
        end else begin
            playerHit <= |slot_hit;
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        state_q <= ST_LOAD;
                        idx_q   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (entry_live && !free_found && (dropCount != 8'hFF)) begin
                        dropCount <= dropCount + 8'd1;
                    end
                    if (idx_q == 3'(VOLLEY_SIZE - 1)) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        proj_slot #(
            .PROJ_SPEED (PROJ_SPEED),
            .DIAG_SPEED (DIAG_SPEED),
            .BEAM_LIFE  (BEAM_LIFE)
        ) u_slot (
            .clk_master  (clk_master),
            .rst         (rst),
            .pulse_frame (pulse_frame),
            .wr_en       (wr_vec[g]),
            .wr_type     (cap_type),
            .wr_dir_left (idx_q == 3'd0),
            .wr_x        (cur_entry.x),
            .wr_y        (cur_entry.y),
            .wr_w        (cap_w),
            .wr_h        (cap_h),
            .player_x    (playerX),
            .player_y    (playerY),
            .player_w    (playerW),
            .player_h    (playerH),
            .valid       (slotValid[g]),
            .x           (slotX[10*g +: 10]),
            .y           (slotY[9*g +: 9]),
            .w           (slotW[10*g +: 10]),
            .h           (slotH[9*g +: 9]),
            .hit         (slot_hit[g])
        );
    end

endmodule

// File: tb/tb_boss_projectile_engine.sv
// ---------------------------------------------------------------------------
// tb_boss_projectile_engine
// Directed, self-checking bench for boss_projectile_engine. Inputs change and
// outputs are sampled on the falling clock edge; expected values are
// hand-computed from the projectile rules.
// ---------------------------------------------------------------------------
module tb_boss_projectile_engine;

    localparam int SLOTS = 10;

    logic              clk_master = 1'b0;
    logic              rst;
    logic              pulse_frame;
    logic              bossShoot;
    logic [1:0]        attackType;
    logic [9:0]        vx [5];
    logic [8:0]        vy [5];
    logic [9:0]        projW;
    logic [8:0]        projH;
    logic [9:0]        playerX;
    logic [8:0]        playerY;
    logic [9:0]        playerW;
    logic [8:0]        playerH;
    logic [SLOTS-1:0]  slotValid;
    logic [10*SLOTS-1:0] slotX;
    logic [9*SLOTS-1:0]  slotY;
    logic [10*SLOTS-1:0] slotW;
    logic [9*SLOTS-1:0]  slotH;
    logic              playerHit;
    logic [7:0]        dropCount;

    int n_compared   = 0;
    int n_mismatched = 0;
    int hit_pulses   = 0;
    int hit_base;

    boss_projectile_engine dut (
        .clk_master  (clk_master),
        .rst         (rst),
        .pulse_frame (pulse_frame),
        .bossShoot   (bossShoot),
        .attackType  (attackType),
        .proj1X      (vx[0]),
        .proj2X      (vx[1]),
        .proj3X      (vx[2]),
        .proj4X      (vx[3]),
        .proj5X      (vx[4]),
        .proj1Y      (vy[0]),
        .proj2Y      (vy[1]),
        .proj3Y      (vy[2]),
        .proj4Y      (vy[3]),
        .proj5Y      (vy[4]),
        .projW       (projW),
        .projH       (projH),
        .playerX     (playerX),
        .playerY     (playerY),
        .playerW     (playerW),
        .playerH     (playerH),
        .slotValid   (slotValid),
        .slotX       (slotX),
        .slotY       (slotY),
        .slotW       (slotW),
        .slotH       (slotH),
        .playerHit   (playerHit),
        .dropCount   (dropCount)
    );

    always #5 clk_master = ~clk_master;

    // Counts every cycle playerHit is seen high.
    always @(negedge clk_master) begin
        if (!rst && playerHit) hit_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int get_x(input int i);
        return int'(slotX[10*i +: 10]);
    endfunction

    function automatic int get_y(input int i);
        return int'(slotY[9*i +: 9]);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_master);
    endtask

    task automatic do_reset();
        @(negedge clk_master);
        rst         = 1'b1;
        pulse_frame = 1'b0;
        bossShoot   = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic clear_volley();
        for (int i = 0; i < 5; i++) begin
            vx[i] = '0;
            vy[i] = '0;
        end
    endtask

    // Strobe is captured on the rising edge inside this task; returns on the
    // following falling edge.
    task automatic shoot(input logic [1:0] t, input logic [9:0] w, input logic [8:0] h);
        @(negedge clk_master);
        bossShoot  = 1'b1;
        attackType = t;
        projW      = w;
        projH      = h;
        @(negedge clk_master);
        bossShoot = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk_master);
        pulse_frame = 1'b1;
        @(negedge clk_master);
        pulse_frame = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pulse_frame = 1'b0; bossShoot = 1'b0; attackType = 2'b00;
        projW = '0; projH = '0;
        playerX = '0; playerY = '0; playerW = '0; playerH = '0;
        clear_volley();
        do_reset();

        // T1: reset asserted in the middle of a load.
        vx[0] = 10'd259; vx[1] = 10'd359; vx[2] = 10'd459; vx[3] = 10'd559; vx[4] = 10'd659;
        for (int i = 0; i < 5; i++) vy[i] = 9'd231;
        shoot(2'b00, 10'd10, 9'd10);
        tick(2);
        check("t1_midload_valid", 32'(slotValid), 32'h3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("t1_reset_valid", 32'(slotValid), 32'h0);
        check("t1_reset_hit", 32'(playerHit), 32'h0);
        check("t1_reset_drop", 32'(dropCount), 32'h0);
        tick(6);
        check("t1_load_aborted", 32'(slotValid), 32'h0);

        // T2: five straight projectiles.
        shoot(2'b00, 10'd10, 9'd10);
        tick(4);
        check("t2_valid_4cyc", 32'(slotValid), 32'h0F);
        tick(1);
        check("t2_valid_5cyc", 32'(slotValid), 32'h1F);
        check("t2_x0", 32'(get_x(0)), 32'd259);
        check("t2_x4", 32'(get_x(4)), 32'd659);
        frame();
        for (int i = 0; i < 5; i++) check($sformatf("t2_y%0d", i), 32'(get_y(i)), 32'd235);
        check("t2_valid_after_frame", 32'(slotValid), 32'h1F);

        // T3: ignored attack type, then despawn at the bottom edge.
        do_reset();
        clear_volley();
        vx[0] = 10'd300; vy[0] = 9'd200;
        shoot(2'b11, 10'd10, 9'd10);
        tick(6);
        check("t3_type11_ignored", 32'(slotValid), 32'h0);
        vy[0] = 9'd505;
        shoot(2'b00, 10'd10, 9'd10);
        tick(5);
        check("t3_single_valid", 32'(slotValid), 32'h1);
        frame();
        check("t3_f1_y", 32'(get_y(0)), 32'd509);
        check("t3_f1_valid", 32'(slotValid), 32'h1);
        frame();
        check("t3_f2_freed", 32'(slotValid), 32'h0);

        // T4: beam over the player, hits once, expires after 60 frames.
        do_reset();
        clear_volley();
        vx[0] = 10'd234; vy[0] = 9'd231;
        playerX = 10'd250; playerY = 9'd300; playerW = 10'd20; playerH = 9'd20;
        hit_base = hit_pulses;
        shoot(2'b01, 10'd60, 9'd280);
        tick(5);
        check("t4_beam_valid", 32'(slotValid), 32'h1);
        frame();
        check("t4_hit_pulse", 32'(playerHit), 32'h1);
        tick(1);
        check("t4_hit_one_cycle", 32'(playerHit), 32'h0);
        repeat (58) frame();
        check("t4_f59_valid", 32'(slotValid), 32'h1);
        check("t4_f59_x", 32'(get_x(0)), 32'd234);
        check("t4_f59_y", 32'(get_y(0)), 32'd231);
        frame();
        check("t4_f60_freed", 32'(slotValid), 32'h0);
        tick(1);
        check("t4_hit_count", 32'(hit_pulses - hit_base), 32'd1);
        playerX = '0; playerY = '0; playerW = '0; playerH = '0;

        // T5: diagonal pair drifting apart.
        do_reset();
        clear_volley();
        vx[0] = 10'd244; vy[0] = 9'd231;
        vx[1] = 10'd684; vy[1] = 9'd231;
        shoot(2'b10, 10'd10, 9'd10);
        tick(5);
        check("t5_valid", 32'(slotValid), 32'h3);
        frame();
        check("t5_f1_x0", 32'(get_x(0)), 32'd241);
        check("t5_f1_x1", 32'(get_x(1)), 32'd687);
        check("t5_f1_y0", 32'(get_y(0)), 32'd234);
        check("t5_f1_y1", 32'(get_y(1)), 32'd234);
        for (int n = 2; n <= 34; n++) begin
            frame();
            if (n == 30) begin
                check("t5_f30_right_valid", 32'(slotValid[1]), 32'h1);
                check("t5_f30_x1", 32'(get_x(1)), 32'd774);
            end
            if (n == 31) check("t5_f31_right_freed", 32'(slotValid[1]), 32'h0);
            if (n == 33) begin
                check("t5_f33_left_valid", 32'(slotValid[0]), 32'h1);
                check("t5_f33_x0", 32'(get_x(0)), 32'd145);
            end
            if (n == 34) check("t5_f34_left_freed", 32'(slotValid[0]), 32'h0);
        end

        // T6: full pool drops, strobe during LOAD ignored, empty entry skipped.
        do_reset();
        for (int i = 0; i < 5; i++) begin vx[i] = 10'(200 + 60*i); vy[i] = 9'd100; end
        shoot(2'b00, 10'd10, 9'd10);
        tick(5);
        for (int i = 0; i < 5; i++) vx[i] = 10'(500 + 50*i);
        shoot(2'b00, 10'd10, 9'd10);
        tick(5);
        check("t6_pool_full", 32'(slotValid), 32'h3FF);
        for (int i = 0; i < 5; i++) begin vx[i] = 10'(150 + 20*i); vy[i] = 9'd50; end
        shoot(2'b00, 10'd10, 9'd10);
        tick(2);
        bossShoot = 1'b1;
        @(negedge clk_master);
        bossShoot = 1'b0;
        tick(5);
        check("t6_drop5", 32'(dropCount), 32'd5);
        check("t6_pool_unchanged", 32'(slotValid), 32'h3FF);
        check("t6_slot0_x", 32'(get_x(0)), 32'd200);
        check("t6_slot0_y", 32'(get_y(0)), 32'd100);
        vx[4] = '0; vy[4] = '0;
        shoot(2'b00, 10'd10, 9'd10);
        tick(6);
        check("t6_drop9", 32'(dropCount), 32'd9);

        // T7: frame tick coincident with the write of the second entry.
        do_reset();
        clear_volley();
        vx[0] = 10'd300; vy[0] = 9'd200;
        vx[1] = 10'd400; vy[1] = 9'd200;
        shoot(2'b00, 10'd10, 9'd10);
        @(negedge clk_master);
        pulse_frame = 1'b1;
        @(negedge clk_master);
        pulse_frame = 1'b0;
        tick(4);
        check("t7_valid", 32'(slotValid), 32'h3);
        check("t7_moved_y0", 32'(get_y(0)), 32'd204);
        check("t7_spawn_y1", 32'(get_y(1)), 32'd200);
        frame();
        check("t7_f_y0", 32'(get_y(0)), 32'd208);
        check("t7_f_y1", 32'(get_y(1)), 32'd204);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
